// File: rtl/redmule_tile_obi_demux.sv
// OBI request demultiplexer that routes one core port to an L1SPM or L2 target by address.
// Define REDMULE_TILE_OBI_DEMUX_ERR_EN to answer unmapped addresses locally with an error response.
module redmule_tile_obi_demux #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned N_MAX_TRAN = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mgr_req_i,
    output logic                  mgr_gnt_o,
    input  logic [ADDR_W-1:0]     mgr_addr_i,
    input  logic                  mgr_we_i,
    input  logic [DATA_W/8-1:0]   mgr_be_i,
    input  logic [DATA_W-1:0]     mgr_wdata_i,
    output logic                  mgr_rvalid_o,
    output logic [DATA_W-1:0]     mgr_rdata_o,
    output logic                  mgr_err_o,
    output logic [1:0]            sbr_req_o,
    input  logic [1:0]            sbr_gnt_i,
    output logic [ADDR_W-1:0]     sbr_addr_o,
    output logic                  sbr_we_o,
    output logic [DATA_W/8-1:0]   sbr_be_o,
    output logic [DATA_W-1:0]     sbr_wdata_o,
    input  logic [1:0]            sbr_rvalid_i,
    input  logic [2*DATA_W-1:0]   sbr_rdata_i,
    input  logic [1:0]            sbr_err_i,
    output logic                  busy_o
);

    localparam int unsigned CNT_W = $clog2(N_MAX_TRAN + 1);

    logic [CNT_W-1:0] cnt;
    logic             last_sel;
    logic             err_pend;
    logic [63:0]      addr_ext;
    logic             sel;
    logic             err_req;
    logic             can_fwd;
    logic             hs;
    logic             err_hs;
    logic             rsp;

    assign addr_ext = 64'(mgr_addr_i);
    // Target 1 is the L1SPM window; everything else goes to L2 unless flagged unmapped below.
    assign sel      = (addr_ext >= 64'h1000_0000) && (addr_ext < 64'h2000_0000);

`ifdef REDMULE_TILE_OBI_DEMUX_ERR_EN
    assign err_req = mgr_req_i && !sel &&
                     !((addr_ext >= 64'h2000_0000) && (addr_ext < 64'h3000_0000));
`else
    assign err_req = 1'b0;
`endif

    // Only one target may have responses in flight, which keeps responses in request order.
    assign can_fwd = (cnt < CNT_W'(N_MAX_TRAN)) && ((cnt == '0) || (sel == last_sel)) && !err_pend;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        sbr_req_o = 2'b00;
        mgr_gnt_o = 1'b0;
        if (err_req) begin
            mgr_gnt_o = (cnt == '0) && !err_pend;
        end else if (can_fwd) begin
            sbr_req_o[sel] = mgr_req_i;
            mgr_gnt_o      = mgr_req_i && sbr_gnt_i[sel];
        end
    end

    assign hs     = mgr_req_i && mgr_gnt_o && !err_req;
    assign err_hs = err_req && mgr_gnt_o;
    assign rsp    = (cnt != '0) && sbr_rvalid_i[last_sel];

    always_comb begin
        mgr_rvalid_o = 1'b0;
        mgr_rdata_o  = '0;
        mgr_err_o    = 1'b0;
        if (err_pend) begin
            mgr_rvalid_o = 1'b1;
            mgr_err_o    = 1'b1;
        end else if (rsp) begin
            mgr_rvalid_o = 1'b1;
            mgr_rdata_o  = last_sel ? sbr_rdata_i[2*DATA_W-1:DATA_W] : sbr_rdata_i[DATA_W-1:0];
            mgr_err_o    = sbr_err_i[last_sel];
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            last_sel <= 1'b0;
            err_pend <= 1'b0;
        end else begin
            cnt      <= cnt + CNT_W'(hs) - CNT_W'(rsp);
            err_pend <= err_hs;
            if (hs) begin
                last_sel <= sel;
            end
        end
    end

    assign sbr_addr_o  = mgr_addr_i;
    assign sbr_we_o    = mgr_we_i;
    assign sbr_be_o    = mgr_be_i;
    assign sbr_wdata_o = mgr_wdata_i;
    assign busy_o      = (cnt != '0) || err_pend;

endmodule

// File: doc/redmule_tile_obi_demux.md
REDMULE_TILE_OBI_DEMUX -- requirements
Module: redmule_tile_obi_demux

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter N_MAX_TRAN, default 1, max outstanding transactions (1..8).
REQ-004 SHALL have ports (name direction width meaning), listed below:
- clk_i  in  1  single clock.
- rst_i  in  1  asynchronous active-high reset.
- mgr_req_i  in  1  core data request.
- mgr_gnt_o  out  1  grant to core.
- mgr_addr_i  in  ADDR_W  request address.
- mgr_we_i  in  1  write enable.
- mgr_be_i  in  DATA_W/8  byte enables.
- mgr_wdata_i  in  DATA_W  write data.
- mgr_rvalid_o  out  1  response valid.
- mgr_rdata_o  out  DATA_W  response data.
- mgr_err_o  out  1  response error.
- sbr_req_o  out  2  per-target request; bit 1 = L1SPM, bit 0 = L2.
- sbr_gnt_i  in  2  per-target grant.
- sbr_addr_o, sbr_we_o, sbr_be_o, sbr_wdata_o  out  ADDR_W/1/DATA_W/8/DATA_W  broadcast copies of mgr fields.
- sbr_rvalid_i  in  2  per-target response valid.
- sbr_rdata_i  in  2*DATA_W  per-target read data; [DATA_W-1:0] = L2.
- sbr_err_i  in  2  per-target error.
- busy_o  out  1  high while any transaction outstanding.

Function
REQ-005 SHALL decode combinationally: [0x1000_0000, 0x2000_0000) -> target 1 (L1SPM); [0x2000_0000, 0x3000_0000) -> target 0 (L2); else unmapped.
REQ-006 SHALL keep outstanding counter cnt (0..N_MAX_TRAN) and register last_sel.
REQ-007 SHALL forward request (sbr_req_o[sel]=mgr_req_i) only if cnt<N_MAX_TRAN and (cnt==0 or sel==last_sel); else stall: sbr_req_o=0, mgr_gnt_o=0.
REQ-008 SHALL drive mgr_gnt_o = sbr_gnt_i[sel] when forwarding; zero latency, no request buffering.
REQ-009 SHALL, on handshake, increment cnt and set last_sel<=sel.
REQ-010 SHALL, while cnt>0, drive mgr_rvalid_o/rdata_o/err_o from target last_sel; each sbr_rvalid_i[last_sel] decrements cnt.
REQ-011 SHALL leave cnt unchanged on same-cycle handshake and response.
REQ-012 SHALL ignore sbr_rvalid_i from a non-last_sel target or when cnt==0 (not forwarded, no counter change).
REQ-013 SHALL drive mgr_rdata_o=0, mgr_err_o=0 when mgr_rvalid_o=0.
REQ-014 SHALL assert busy_o = (cnt!=0) or error response pending.
REQ-015 SHALL preserve response order (guaranteed by single-target rule REQ-007).

Reset
REQ-016 SHALL on rst_i asynchronously clear cnt, last_sel, error-pending flag; all outputs 0.
REQ-017 SHALL drop transactions outstanding at reset; late responses after release ignored per REQ-012.

Configuration
REQ-018 SHALL honour macro REDMULE_TILE_OBI_DEMUX_ERR_EN.
REQ-019 With macro: unmapped request granted only when cnt==0 and no error pending, no sbr_req_o; next cycle mgr_rvalid_o=1, mgr_err_o=1, mgr_rdata_o=0; busy_o high in between.
REQ-020 Without macro: unmapped addresses route to target 0 (L2) as normal requests; mgr_err_o only mirrors sbr_err_i.

Verification
REQ-021 Read 0x1000_0040, sbr_gnt_i=2'b10 same cycle, rvalid[1] next cycle rdata 0xCAFE_F00D -> mgr_gnt_o=1 cycle 0, mgr_rvalid_o=1 rdata 0xCAFE_F00D cycle 1, cnt back to 0.
REQ-022 N_MAX_TRAN=1: L2 read 0x2000_0000 outstanding, new L1 request 0x1000_0000 -> sbr_req_o=0, mgr_gnt_o=0 until L2 rvalid, then granted.
REQ-023 N_MAX_TRAN=2: two L2 writes back-to-back, response of first same cycle as second grant -> cnt stays 1, busy_o=1, both responses delivered in order.
REQ-024 ERR_EN defined: read 0x4000_0000 -> gnt same cycle, sbr_req_o=0, next cycle rvalid=1 err=1 rdata=0; undefined: sbr_req_o=2'b01.
REQ-025 rst_i pulsed with cnt=1, stray sbr_rvalid_i[0]=1 after release -> mgr_rvalid_o=0, busy_o=0, cnt=0.
